uart_unit_cfg: RTL and testbench
================================

// Module: uart_unit_cfg
// PURPOSE
//  Runtime-configurable UART: 5-8 data bits, none/even/odd parity, 1/1.5/2 stop bits, x16 oversampling.
//  Parametrised TX/RX FIFO depth. RX path carries per-byte error flags and sticky status flags.
//  Successor to the fixed-format UART unit. Sits between the bus-side register interface and the serial pins.
// PARAMETERS
//  FIFO_W    2   FIFO address bits; each FIFO holds 2**FIFO_W entries.
//  SB_MAX   32   width reference for the stop-tick counter (supports up to 2 stop bits).
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  dvsr        in  11   baud divisor; one tick every dvsr+1 clocks (16 ticks per bit)
//  cfg_dbit    in   2   00=5, 01=6, 10=7, 11=8 data bits
//  cfg_par     in   2   00=none, 01=even, 10=odd, 11=none
//  cfg_stop    in   2   00=1, 01=1.5, 10=2, 11=2 stop bits
//  wr_uart     in   1   push w_data into TX FIFO
//  w_data      in   8   TX byte; only bits [n-1:0] are sent
//  rd_uart     in   1   pop RX FIFO head
//  clr_err     in   1   clear sticky error flags
//  rx          in   1   serial input (pre-synchronised)
//  tx          out  1   serial output
//  r_data      out  8   RX FIFO head; unused upper bits = 0
//  r_err       out  2   head flags {frame_err, parity_err}
//  tx_full     out  1   TX FIFO full
//  tx_idle     out  1   TX FIFO empty and TX FSM idle
//  rx_empty    out  1   RX FIFO empty
//  st_perr, st_ferr, st_ovr   out  1 each   sticky parity / framing / overrun error
// BEHAVIOUR
//  Reset: tx=1, tx_idle=1, rx_empty=1, tx_full=0, r_data=0, r_err=0, sticky flags=0; both FSMs IDLE; FIFOs empty.
//  Tick counter: counts 0..dvsr and pulses tick when it reaches dvsr. dvsr=0 gives a tick every clock.
//  Config latch: cfg_* are sampled on leaving IDLE. Changes mid-frame take effect on the next frame.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE
//   - Leaves IDLE when the TX FIFO is non-empty; the head word is latched.
//   - Each bit lasts 16 ticks; data is sent LSB first.
//   - PARITY state is skipped when parity is none. Parity bit: even = XOR of data bits; odd = its inverse.
//   - STOP lasts 16/24/32 ticks.
//   - The FIFO is popped in the same cycle STOP ends. With data still queued, START follows next clock (back-to-back frames).
//  RX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE
//   - Leaves IDLE when rx falls.
//   - START samples rx at tick 7. If rx=1, the frame is discarded as a glitch and the FSM returns to IDLE with no write.
//   - Each later bit is sampled at tick 15 of its 16.
//   - STOP is sampled once, 16 ticks in, regardless of stop config. The FSM then returns to IDLE, allowing 1.5/2-stop
//     senders to be received.
//   - Parity error: received parity bit != computed parity. Frame error: stop sample = 0.
//   - The FIFO is written one clock after the stop sample with {ferr, perr, data zero-extended}. The sticky flags
//     OR-in the same error bits.
//   - Overrun: completed frame while the RX FIFO is full and rd_uart=0. The word is dropped and st_ovr is set.
//     Existing contents are untouched.
//  Flags: clr_err clears all sticky flags. If clr_err coincides with a new error, set wins.
//  FIFO rules (both FIFOs):
//   - wr while full is ignored; rd while empty is ignored.
//   - rd and wr in the same cycle when full: both occur. When empty: write only.
//   - Wrap-around at 2**FIFO_W.
//   - r_data/r_err show the head combinationally. Pop takes effect on the next edge.
//  Reset mid-frame: all state returns to reset values immediately (async); a partial frame is lost and tx goes high.
// STRUCTURE
//  Shared package uart_pkg:
//   - Encodings for cfg_dbit, cfg_par and cfg_stop.
//   - FSM state encodings: IDLE, START, DATA, PARITY, STOP.
//   - OVS=16 and the stop-tick table 16/24/32.
//  Reuse fifo_unit twice: TX with DATA_WIDTH=8, RX with DATA_WIDTH=10.
//  One new sub-module, uart_frame_rx (RX FSM with parity/framing check), is natural.
//  TX FSM, tick counter and sticky flags stay inline.
// TESTING
//  1. dvsr=0, 8N1, write 0xA5 -> tx low 16 ticks, bits 1,0,1,0,0,1,0,1, high 16 ticks; tx_idle returns 1.
//  2. 7E2, write 0x41 (7 data bits, two 1s) -> parity bit 0, 32-tick stop. Loopback rx=tx -> r_data=0x41, r_err=00.
//  3. 8O1, inject RX frame 0x3C with parity bit 0 and stop bit 0 -> r_err=11, st_perr=st_ferr=1.
//     clr_err then clears both flags.
//  4. 4-deep RX FIFO, send 5 frames with no reads -> frames 1-4 intact, st_ovr=1, rx_empty=0.
//  5. 2-tick rx low pulse -> no FIFO write, FSM back in IDLE. Then a full frame 0x5A is received correctly.
//  6. Assert reset_n mid-TX-DATA -> tx=1 within the same cycle. After release a new write transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART encodings: config fields, FSM states, oversampling and stop-length helpers.
package uart_pkg;
  localparam logic [1:0] DBIT_5 = 2'b00, DBIT_6 = 2'b01, DBIT_7 = 2'b10, DBIT_8 = 2'b11;
  localparam logic [1:0] PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10;
  localparam logic [1:0] STOP_1 = 2'b00, STOP_1P5 = 2'b01, STOP_2 = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int OVS = 16;

  // Index of the last data bit: 5..8 bits map to 4..7.
  function automatic logic [2:0] last_bit(input logic [1:0] dbit);
    return {1'b1, dbit};
  endfunction

  function automatic logic par_on(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  function automatic int stop_ticks(input logic [1:0] stop);
    case (stop)
      STOP_1:   return OVS;
      STOP_1P5: return OVS + OVS / 2;
      default:  return 2 * OVS;
    endcase
  endfunction

  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] dbit,
                                   input logic [1:0] par);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - dbit);
    return (^(d & mask)) ^ (par == PAR_ODD);
  endfunction
endpackage

// File: rtl/fifo_unit.sv
// Generic FIFO with combinational head; write-when-full ignored unless a pop happens in the same cycle.
module fifo_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_empty,
  output logic                  o_full
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   r_wptr, r_rptr;
  logic                  w_do_wr, w_do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty  = (r_wptr == r_rptr);
  assign o_full   = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                    (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
  assign w_do_rd  = i_rd && !o_empty;
  assign w_do_wr  = i_wr && (!o_full || i_rd);
  assign o_r_data = r_mem[r_rptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= i_w_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_frame_rx.sv
// RX framer: start-bit glitch rejection, mid-bit sampling, parity/framing check.
// o_done pulses one clock after the stop sample; no backpressure (the caller handles overrun).
module uart_frame_rx
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_rx,
  input  logic [1:0] i_cfg_dbit,
  input  logic [1:0] i_cfg_par,
  output logic       o_done,
  output logic [7:0] o_data,
  output logic       o_perr,
  output logic       o_ferr
);
  logic [2:0] r_st;
  logic [3:0] r_s;
  logic [2:0] r_n;
  logic [7:0] r_b;
  logic       r_pbit;
  logic [1:0] r_dbit, r_par;
  logic [7:0] w_data;

  // Bits shift in from the MSB, so short frames need right-aligning.
  assign w_data = r_b >> (2'd3 - r_dbit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st <= ST_IDLE; r_s <= '0; r_n <= '0; r_b <= '0; r_pbit <= 1'b0;
      r_dbit <= '0; r_par <= '0;
      o_done <= 1'b0; o_data <= '0; o_perr <= 1'b0; o_ferr <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_st)
        ST_IDLE: if (!i_rx) begin
          r_st <= ST_START; r_s <= '0; r_n <= '0;
          r_dbit <= i_cfg_dbit; r_par <= i_cfg_par;
        end
        ST_START: if (i_tick) begin
          if (r_s == 4'd7) begin
            r_s  <= '0;
            r_st <= i_rx ? ST_IDLE : ST_DATA;
          end else r_s <= r_s + 1'b1;
        end
        ST_DATA: if (i_tick) begin
          if (r_s == 4'(OVS - 1)) begin
            r_s <= '0;
            r_b <= {i_rx, r_b[7:1]};
            if (r_n == last_bit(r_dbit)) r_st <= par_on(r_par) ? ST_PARITY : ST_STOP;
            else r_n <= r_n + 1'b1;
          end else r_s <= r_s + 1'b1;
        end
        ST_PARITY: if (i_tick) begin
          if (r_s == 4'(OVS - 1)) begin
            r_s <= '0; r_pbit <= i_rx; r_st <= ST_STOP;
          end else r_s <= r_s + 1'b1;
        end
        ST_STOP: if (i_tick) begin
          if (r_s == 4'(OVS - 1)) begin
            r_st   <= ST_IDLE;
            o_done <= 1'b1;
            o_data <= w_data;
            o_ferr <= !i_rx;
            o_perr <= par_on(r_par) && (r_pbit != par_bit(w_data, r_dbit, r_par));
          end else r_s <= r_s + 1'b1;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_unit_cfg.sv
// Configurable UART: baud tick, TX FSM, RX framer, TX/RX FIFOs and sticky error flags.
// TX starts one clock after its FIFO goes non-empty; RX overrun drops the new word and sets st_ovr.
module uart_unit_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_W = 2,
  parameter int SB_MAX = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] dvsr,
  input  logic [1:0]  cfg_dbit,
  input  logic [1:0]  cfg_par,
  input  logic [1:0]  cfg_stop,
  input  logic        wr_uart,
  input  logic [7:0]  w_data,
  input  logic        rd_uart,
  input  logic        clr_err,
  input  logic        rx,
  output logic        tx,
  output logic [7:0]  r_data,
  output logic [1:0]  r_err,
  output logic        tx_full,
  output logic        tx_idle,
  output logic        rx_empty,
  output logic        st_perr,
  output logic        st_ferr,
  output logic        st_ovr
);
  localparam int SW = $clog2(SB_MAX);

  logic [10:0]   r_tick_cnt;
  logic          w_tick;
  logic [2:0]    r_tx_st;
  logic [SW-1:0] r_tx_s;
  logic [2:0]    r_tx_n;
  logic [7:0]    r_tx_b;
  logic          r_tx_pbit;
  logic [1:0]    r_tx_dbit, r_tx_par, r_tx_stop;
  logic [7:0]    w_txf_dat;
  logic          w_txf_empty, w_tx_pop, w_tx;
  logic          w_rx_done, w_rx_perr, w_rx_ferr, w_rxf_full, w_ovr;
  logic [7:0]    w_rx_data;
  logic [9:0]    w_rxf_dat;
  logic          r_st_perr, r_st_ferr, r_st_ovr;

  assign w_tick = (r_tick_cnt == dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tick_cnt <= '0;
    else          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_st <= ST_IDLE; r_tx_s <= '0; r_tx_n <= '0; r_tx_b <= '0; r_tx_pbit <= 1'b0;
      r_tx_dbit <= '0; r_tx_par <= '0; r_tx_stop <= '0;
    end else begin
      case (r_tx_st)
        ST_IDLE: if (!w_txf_empty) begin
          r_tx_st <= ST_START; r_tx_s <= '0; r_tx_n <= '0; r_tx_b <= w_txf_dat;
          r_tx_dbit <= cfg_dbit; r_tx_par <= cfg_par; r_tx_stop <= cfg_stop;
          r_tx_pbit <= par_bit(w_txf_dat, cfg_dbit, cfg_par);
        end
        ST_START: if (w_tick) begin
          if (r_tx_s == SW'(OVS - 1)) begin r_tx_s <= '0; r_tx_st <= ST_DATA; end
          else r_tx_s <= r_tx_s + 1'b1;
        end
        ST_DATA: if (w_tick) begin
          if (r_tx_s == SW'(OVS - 1)) begin
            r_tx_s <= '0;
            r_tx_b <= r_tx_b >> 1;
            if (r_tx_n == last_bit(r_tx_dbit)) r_tx_st <= par_on(r_tx_par) ? ST_PARITY : ST_STOP;
            else r_tx_n <= r_tx_n + 1'b1;
          end else r_tx_s <= r_tx_s + 1'b1;
        end
        ST_PARITY: if (w_tick) begin
          if (r_tx_s == SW'(OVS - 1)) begin r_tx_s <= '0; r_tx_st <= ST_STOP; end
          else r_tx_s <= r_tx_s + 1'b1;
        end
        ST_STOP: if (w_tick) begin
          if (w_tx_pop) r_tx_st <= ST_IDLE;
          else r_tx_s <= r_tx_s + 1'b1;
        end
        default: r_tx_st <= ST_IDLE;
      endcase
    end
  end

  // Head word leaves the FIFO on the tick that ends the stop period.
  assign w_tx_pop = (r_tx_st == ST_STOP) && w_tick &&
                    (r_tx_s == SW'(stop_ticks(r_tx_stop) - 1));

  always_comb begin
    w_tx = 1'b1;
    case (r_tx_st)
      ST_START:  w_tx = 1'b0;
      ST_DATA:   w_tx = r_tx_b[0];
      ST_PARITY: w_tx = r_tx_pbit;
      default:   w_tx = 1'b1;
    endcase
  end

  assign tx      = w_tx;
  assign tx_idle = w_txf_empty && (r_tx_st == ST_IDLE);

  fifo_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(FIFO_W)) u_tx_fifo (
    .i_clk(clk), .i_rst_n(reset_n), .i_wr(wr_uart), .i_rd(w_tx_pop), .i_w_data(w_data),
    .o_r_data(w_txf_dat), .o_empty(w_txf_empty), .o_full(tx_full)
  );

  uart_frame_rx u_rx (
    .i_clk(clk), .i_rst_n(reset_n), .i_tick(w_tick), .i_rx(rx),
    .i_cfg_dbit(cfg_dbit), .i_cfg_par(cfg_par),
    .o_done(w_rx_done), .o_data(w_rx_data), .o_perr(w_rx_perr), .o_ferr(w_rx_ferr)
  );

  fifo_unit #(.DATA_WIDTH(10), .ADDR_WIDTH(FIFO_W)) u_rx_fifo (
    .i_clk(clk), .i_rst_n(reset_n), .i_wr(w_rx_done), .i_rd(rd_uart),
    .i_w_data({w_rx_ferr, w_rx_perr, w_rx_data}),
    .o_r_data(w_rxf_dat), .o_empty(rx_empty), .o_full(w_rxf_full)
  );

  assign r_data = rx_empty ? 8'h00 : w_rxf_dat[7:0];
  assign r_err  = rx_empty ? 2'b00 : w_rxf_dat[9:8];
  assign w_ovr  = w_rx_done && w_rxf_full && !rd_uart;

  // Set has priority over clr_err so a coincident error is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st_perr <= 1'b0; r_st_ferr <= 1'b0; r_st_ovr <= 1'b0;
    end else begin
      r_st_perr <= (r_st_perr && !clr_err) || (w_rx_done && w_rx_perr);
      r_st_ferr <= (r_st_ferr && !clr_err) || (w_rx_done && w_rx_ferr);
      r_st_ovr  <= (r_st_ovr  && !clr_err) || w_ovr;
    end
  end

  assign st_perr = r_st_perr;
  assign st_ferr = r_st_ferr;
  assign st_ovr  = r_st_ovr;
endmodule

// File: tb/tb_uart_unit_cfg.sv
// Bench for uart_unit_cfg: TX waveform checks and an RX scoreboard of {r_err, r_data} words.
module tb_uart_unit_cfg;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] dvsr;
  logic [1:0]  cfg_dbit, cfg_par, cfg_stop;
  logic        wr_uart, rd_uart, clr_err;
  logic [7:0]  w_data;
  logic        rx_drv, loop_en, w_rx;
  logic        tx, tx_full, tx_idle, rx_empty, st_perr, st_ferr, st_ovr;
  logic [7:0]  r_data;
  logic [1:0]  r_err;

  int n_chk = 0;
  int n_bad = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;
  assign w_rx = loop_en ? tx : rx_drv;

  uart_unit_cfg dut (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr),
    .cfg_dbit(cfg_dbit), .cfg_par(cfg_par), .cfg_stop(cfg_stop),
    .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart), .clr_err(clr_err),
    .rx(w_rx), .tx(tx), .r_data(r_data), .r_err(r_err),
    .tx_full(tx_full), .tx_idle(tx_idle), .rx_empty(rx_empty),
    .st_perr(st_perr), .st_ferr(st_ferr), .st_ovr(st_ovr)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic tb_par(input logic [7:0] d, input int nb, input logic odd);
    logic p = odd;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return p;
  endfunction

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] pa, input logic [1:0] st);
    cfg_dbit = db; cfg_par = pa; cfg_stop = st;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    w_data = b; wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic wait_tx_low();
    int k = 0;
    while (tx !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("tx_fall", 16'(tx), 16'h0);
  endtask

  // dvsr=0: one tick per clock, so each bit is 16 clocks; sample mid-bit.
  task automatic tx_expect(input logic [7:0] d, input int nb, input int par_mode, input int st);
    wait_tx_low();
    repeat (8) @(negedge clk);
    chk("tx_start", 16'(tx), 16'h0);
    for (int i = 0; i < nb; i++) begin
      repeat (16) @(negedge clk);
      chk($sformatf("tx_d%0d", i), 16'(tx), 16'(d[i]));
    end
    if (par_mode == 1 || par_mode == 2) begin
      repeat (16) @(negedge clk);
      chk("tx_par", 16'(tx), 16'(tb_par(d, nb, par_mode == 2)));
    end
    repeat (16) @(negedge clk);
    chk("tx_stop_mid", 16'(tx), 16'h1);
    repeat (st - 12) @(negedge clk);
    chk("tx_stop_late", 16'(tx), 16'h1);
    chk("tx_busy_in_stop", 16'(tx_idle), 16'h0);
    repeat (8) @(negedge clk);
    chk("tx_idle_after", 16'(tx_idle), 16'h1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic par_en,
                            input logic pbit, input logic stopv);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_drv = d[i];
      repeat (16) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = pbit;
      repeat (16) @(negedge clk);
    end
    rx_drv = stopv;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain();
    logic [9:0] exp;
    repeat (4) @(negedge clk);
    while (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("rx_avail", 16'(rx_empty), 16'h0);
      chk("rx_word", 16'({r_err, r_data}), 16'(exp));
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
    end
    chk("rx_empty_end", 16'(rx_empty), 16'h1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; dvsr = 11'd0; wr_uart = 1'b0; rd_uart = 1'b0; clr_err = 1'b0;
    w_data = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
    set_cfg(2'b11, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx), 16'h1);
    chk("rst_tx_idle", 16'(tx_idle), 16'h1);
    chk("rst_rx_empty", 16'(rx_empty), 16'h1);
    chk("rst_tx_full", 16'(tx_full), 16'h0);
    chk("rst_rdata", 16'({r_err, r_data}), 16'h0);
    chk("rst_sticky", 16'({st_perr, st_ferr, st_ovr}), 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 8N1 transmit of 0xA5
    wr_byte(8'hA5);
    tx_expect(8'hA5, 8, 0, 16);

    // 7E2 loopback of 0x41
    set_cfg(2'b10, 2'b01, 2'b10);
    loop_en = 1'b1;
    wr_byte(8'h41);
    sb_q.push_back({2'b00, 8'h41});
    tx_expect(8'h41, 7, 1, 32);
    loop_en = 1'b0;
    drain();

    // 8O1 injected frame with wrong parity and a zero stop bit
    set_cfg(2'b11, 2'b10, 2'b00);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0);
    chk("t3_st_perr", 16'(st_perr), 16'h1);
    chk("t3_st_ferr", 16'(st_ferr), 16'h1);
    sb_q.push_back({2'b11, 8'h3C});
    drain();
    pulse_clr();
    chk("t3_clr", 16'({st_perr, st_ferr}), 16'h0);

    // overrun: five frames into a four-deep RX FIFO
    set_cfg(2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) chk("t4_no_ovr_yet", 16'(st_ovr), 16'h0);
      send_frame(8'(8'h11 * (k + 1)), 8, 1'b0, 1'b0, 1'b1);
      if (k < 4) sb_q.push_back({2'b00, 8'(8'h11 * (k + 1))});
    end
    chk("t4_st_ovr", 16'(st_ovr), 16'h1);
    chk("t4_rx_nonempty", 16'(rx_empty), 16'h0);
    drain();
    pulse_clr();
    chk("t4_clr", 16'(st_ovr), 16'h0);

    // start-bit glitch, then a clean 0x5A
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_glitch_empty", 16'(rx_empty), 16'h1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    sb_q.push_back({2'b00, 8'h5A});
    drain();
    chk("t5_sticky", 16'({st_perr, st_ferr, st_ovr}), 16'h0);

    // reset during a data bit
    wr_byte(8'h00);
    wait_tx_low();
    repeat (40) @(negedge clk);
    chk("t6_tx_mid_data", 16'(tx), 16'h0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_tx", 16'(tx), 16'h1);
    chk("t6_rst_idle", 16'(tx_idle), 16'h1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr_byte(8'h96);
    tx_expect(8'h96, 8, 0, 16);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
